// File: rtl/fifo_frame_arb.sv
// fifo_frame_arb: round-robin frame arbiter between two sample channels feeding a FIFO write port.
// Also tracks FIFO occupancy so a frame is only granted when the FIFO has room for all of it.
module fifo_frame_arb #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 10,
    parameter int FRAME_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ready,
    input  logic                  fifo_wr_vld,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_rd_pop,
    output logic                  grant_ch,
    output logic                  busy,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [DEPTH_WIDTH:0]  occupancy,
    output logic                  err_underflow
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [DEPTH_WIDTH+1:0] DEPTH = (DEPTH_WIDTH+2)'(2**DEPTH_WIDTH);
    localparam logic [DEPTH_WIDTH+1:0] FLEN  = (DEPTH_WIDTH+2)'(FRAME_LEN);
    localparam logic [DEPTH_WIDTH-1:0] LAST  = DEPTH_WIDTH'(FRAME_LEN-1);

    state_t                 state, state_nxt;
    logic                   last_grant;
    logic                   first;
    logic                   beat;
    logic                   last_beat;
    logic                   can_start;
    logic                   pick;
    logic [DEPTH_WIDTH-1:0] beat_cnt;
    logic [DEPTH_WIDTH+1:0] space;

    assign space     = DEPTH - {1'b0, occupancy};
    assign can_start = enable && (|req_valid) && (space >= FLEN);
    assign pick      = (&req_valid) ? ~last_grant : req_valid[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start when a full frame fits, finish on the last beat, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_start) state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: handshake and write port are combinational on the granted channel
    always_comb begin
        beat         = (state == XFER) && req_valid[grant_ch] && fifo_wr_vld;
        last_beat    = beat && (beat_cnt == LAST);
        req_ready    = (state == XFER && fifo_wr_vld) ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;
        fifo_wr_en   = beat;
        fifo_wr_data = grant_ch ? req_data1 : req_data0;
        busy         = state != IDLE;
        frame_done   = state == DONE;
        frame_start  = first;
    end

    // Grant, round-robin history, beat count and first-cycle flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_ch   <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            first      <= 1'b0;
        end else begin
            first <= (state == IDLE) && can_start;
            if (state == IDLE && can_start) begin
                grant_ch <= pick;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == DONE) last_grant <= grant_ch;
        end
    end

    // Occupancy follows writes and pops; a pop from empty is flagged and ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy     <= '0;
            err_underflow <= 1'b0;
        end else if (beat && !fifo_rd_pop) begin
            occupancy <= occupancy + 1'b1;
        end else if (fifo_rd_pop && !beat) begin
            if (occupancy == '0) err_underflow <= 1'b1;
            else                 occupancy     <= occupancy - 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_frame_arb.sv
// tb_fifo_frame_arb: randomized bench comparing fifo_frame_arb against a frame-level reference model.
module tb_fifo_frame_arb;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int FL = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic [1:0]    req_ready;
    logic          fifo_wr_vld = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_rd_pop = 1'b0;
    logic          grant_ch;
    logic          busy;
    logic          frame_start;
    logic          frame_done;
    logic [AW:0]   occupancy;
    logic          err_underflow;

    fifo_frame_arb #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_pop(fifo_rd_pop), .grant_ch(grant_ch), .busy(busy),
        .frame_start(frame_start), .frame_done(frame_done), .occupancy(occupancy),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: beats remaining in the current frame, plus one-cycle done/start markers
    int beats_left;
    int m_ch;
    int m_last;
    int m_occ;
    bit m_done;
    bit m_first;
    bit m_err;
    bit m_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        beats_left = 0;
        m_ch = 0;
        m_last = 1;
        m_occ = 0;
        m_done = 0;
        m_first = 0;
        m_err = 0;
    endtask

    task automatic check_outputs();
        bit in_frame;
        in_frame = beats_left > 0;
        m_beat = in_frame && req_valid[m_ch] && fifo_wr_vld;
        check("req_ready", 32'(req_ready), (in_frame && fifo_wr_vld) ? (32'd1 << m_ch) : 32'd0);
        check("wr_en", 32'(fifo_wr_en), 32'(m_beat));
        check("wr_data", 32'(fifo_wr_data), 32'(m_ch == 1 ? req_data1 : req_data0));
        check("grant", 32'(grant_ch), 32'(m_ch));
        check("busy", 32'(busy), 32'(in_frame || m_done));
        check("start", 32'(frame_start), 32'(m_first));
        check("done", 32'(frame_done), 32'(m_done));
        check("occ", 32'(occupancy), 32'(m_occ));
        check("err", 32'(err_underflow), 32'(m_err));
    endtask

    task automatic model_step();
        bit go;
        go = beats_left == 0 && !m_done && enable && req_valid != 2'b00 && (DEPTH - m_occ) >= FL;
        m_first = go;
        if (m_done) begin
            m_last = m_ch;
            m_done = 0;
        end else if (beats_left > 0) begin
            if (m_beat) begin
                beats_left--;
                if (beats_left == 0) m_done = 1;
            end
        end else if (go) begin
            m_ch = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
            beats_left = FL;
        end
        if (m_beat && !fifo_rd_pop) m_occ++;
        else if (fifo_rd_pop && !m_beat) begin
            if (m_occ == 0) m_err = 1;
            else m_occ--;
        end
    endtask

    task automatic cycle(input int p_en, input int p_val, input int p_wv, input int p_pop, input bit allow_uf);
        @(negedge clk);
        enable      = $urandom_range(99) < p_en;
        req_valid   = {$urandom_range(99) < p_val, $urandom_range(99) < p_val};
        fifo_wr_vld = $urandom_range(99) < p_wv;
        fifo_rd_pop = ($urandom_range(99) < p_pop) && (allow_uf || m_occ > 0);
        req_data0   = DW'($urandom);
        req_data1   = DW'($urandom);
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic quiet_inputs();
        enable = 1'b0;
        req_valid = 2'b00;
        fifo_wr_vld = 1'b0;
        fifo_rd_pop = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) cycle(90, 85, 85, 15, 1'b0);
        repeat (400) cycle(90, 70, 60, 40, 1'b0);
        repeat (300) cycle(50, 50, 50, 50, 1'b0);
        n = 0;
        while (beats_left != 2 && n < 300) begin
            cycle(100, 100, 90, 30, 1'b0);
            n++;
        end
        check("reach_mid_frame", 32'(n < 300), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        quiet_inputs();
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) cycle(100, 100, 80, 30, 1'b0);
        repeat (300) cycle(80, 60, 70, 60, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_frame_arb.md
FIFO_FRAME_ARB -- requirements
Module: fifo_frame_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of sample data passed to the FIFO write port.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 10, log2 of FIFO depth; the occupancy counter is DEPTH_WIDTH+1 bits.
REQ-003 SHALL have parameter FRAME_LEN, default 256, samples per frame; legal range 1..2^DEPTH_WIDTH.
REQ-004 SHALL have ports:
 clk  in  1  single clock for all logic
 rst_n  in  1  asynchronous, active-low reset
 enable  in  1  arbitration enable
 req_valid  in  2  per-channel sample valid, bit i = channel i
 req_data0  in  DATA_WIDTH  channel 0 sample
 req_data1  in  DATA_WIDTH  channel 1 sample
 req_ready  out  2  per-channel sample accept
 fifo_wr_vld  in  1  FIFO write side can accept a word this cycle
 fifo_wr_en  out  1  FIFO write strobe
 fifo_wr_data  out  DATA_WIDTH  FIFO write data
 fifo_rd_pop  in  1  one word left the FIFO this cycle (rd_en and rd_vld)
 grant_ch  out  1  channel owning the current frame
 busy  out  1  frame transfer in progress
 frame_start  out  1  one-cycle pulse, first XFER cycle
 frame_done  out  1  one-cycle pulse, frame complete
 occupancy  out  DEPTH_WIDTH+1  words currently held in FIFO
 err_underflow  out  1  sticky, pop seen while occupancy is 0

Function
REQ-005 SHALL implement FSM states IDLE, XFER, DONE.
REQ-006 IDLE -> XFER when enable=1, at least one req_valid bit=1, and (2^DEPTH_WIDTH - occupancy) >= FRAME_LEN; grant_ch is registered on that transition.
REQ-007 Grant choice SHALL be: single requester wins; with both requesting, the channel other than last_grant wins (round-robin).
REQ-008 Beat SHALL be defined as state==XFER and req_valid[grant_ch]=1 and fifo_wr_vld=1.
REQ-009 req_ready[grant_ch] SHALL equal (state==XFER and fifo_wr_vld); the other req_ready bit SHALL be 0; both SHALL be 0 outside XFER.
REQ-010 fifo_wr_en SHALL equal beat combinationally, and fifo_wr_data SHALL be the granted channel's data, with zero-cycle latency.
REQ-011 Beat counter SHALL clear on entering XFER and increment per beat; the beat with count==FRAME_LEN-1 SHALL move XFER -> DONE.
REQ-012 DONE SHALL last exactly one cycle: frame_done=1, last_grant<=grant_ch, then -> IDLE; the minimum gap between frames is 2 cycles (DONE, IDLE).
REQ-013 frame_start SHALL pulse on the first XFER cycle regardless of beat; busy SHALL be 1 in XFER and DONE.
REQ-014 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next IDLE -> XFER.
REQ-015 Stalls (req_valid or fifo_wr_vld low) SHALL hold the beat counter and state indefinitely.
REQ-016 occupancy SHALL be +1 on beat only, -1 on fifo_rd_pop only, and unchanged on both or neither.
REQ-017 A fifo_rd_pop with occupancy==0 and no beat SHALL leave occupancy at 0 and set err_underflow until reset.
REQ-018 The space check SHALL use the registered occupancy of the IDLE cycle; a frame once started is guaranteed space because only this block writes.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state=IDLE, grant_ch=0, last_grant=1, beat counter=0, occupancy=0, err_underflow=0, and busy/frame_start/frame_done=0.
REQ-020 During reset, req_ready=0 and fifo_wr_en=0 SHALL follow from state=IDLE; fifo_wr_data=req_data0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame with no frame_done; release SHALL synchronise to the clk rising edge.

Verification (FRAME_LEN=4, DEPTH_WIDTH=4)
REQ-022 Case: both channels continuously valid, fifo_wr_vld=1, no pops -> frames granted ch0 then ch1; 4 fifo_wr_en per frame; occupancy 4 then 8; frame_done twice.
REQ-023 Case: occupancy=13, ch1 valid -> stays IDLE (space 3<4); one fifo_rd_pop -> occupancy 12, XFER entered next cycle.
REQ-024 Case: fifo_wr_vld toggled 1,0,1,0 during XFER -> req_ready mirrors it; frame completes after exactly 4 beats, 8 cycles.
REQ-025 Case: simultaneous beat and fifo_rd_pop every cycle -> occupancy constant.
REQ-026 Case: pop at occupancy 0 -> err_underflow=1 and occupancy stays 0; enable dropped after beat 2 -> frame finishes and no new grant follows.
REQ-027 Case: rst_n low after beat 2 -> all outputs at reset values immediately; after release, a new frame starts on ch0.
